// File: rtl/type_param_serializer_if.sv
// Stream bundle for type_param_serializer: a wide typed input word and a
// narrow beat stream. The producer/consumer side uses the master modport,
// the serializer uses the slave modport.
interface type_param_serializer_if #(
  parameter type T     = logic [11:0],
  parameter int  OUT_W = 4
);
  localparam int W      = $bits(T);
  localparam int NBEATS = (W + OUT_W - 1) / OUT_W;
  localparam int CW     = ($clog2(NBEATS) > 1) ? $clog2(NBEATS) : 1;

  logic              in_valid;
  logic              in_ready;
  T                  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic [CW-1:0]     out_beat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_beat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_beat
  );
endinterface

// File: rtl/type_param_serializer.sv
// Transmit-side width adapter: takes one value of type T per handshake and
// emits it LSB first as OUT_W-bit beats, flagging the final beat. A new word
// may be accepted in the same cycle the previous last beat leaves, so
// consecutive words stream with no bubble cycles.
module type_param_serializer #(
  parameter type T     = logic [11:0],
  parameter int  OUT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  type_param_serializer_if.slave bus
);
  localparam int W      = $bits(T);
  localparam int NBEATS = (W + OUT_W - 1) / OUT_W;
  localparam int CW     = ($clog2(NBEATS) > 1) ? $clog2(NBEATS) : 1;
  localparam int SW     = NBEATS * OUT_W;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  // A zero or negative beat width has no meaning; stop elaboration.
  generate
    if (OUT_W < 1) begin : g_bad_out_w
      $error("type_param_serializer: OUT_W must be at least 1");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   beat_q,  beat_d;

  logic [W-1:0]    in_bits;
  logic            out_valid;
  logic            out_last;
  logic            in_ready;
  logic            accept;
  logic            xfer;

  // The payload is handled purely as packed bits; zero extension into the
  // wider shift register guarantees the padding bits of the final beat are 0.
  assign in_bits   = bus.in_data;

  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (beat_q == LAST_BEAT);
  assign in_ready  = (state_q == IDLE) || (out_valid && bus.out_ready && out_last);
  assign accept    = bus.in_valid && in_ready;
  assign xfer      = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = shreg_q[OUT_W-1:0];
  assign bus.out_beat  = beat_q;

  // Next-state logic: load on accept (this also covers the reload that
  // overlaps a last-beat transfer), shift on a non-last transfer, and return
  // to idle with cleared registers after a last beat with no new word.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    beat_d  = beat_q;
    if (accept) begin
      shreg_d = SW'(in_bits);
      beat_d  = '0;
      state_d = SEND;
    end else if (xfer) begin
      if (out_last) begin
        shreg_d = '0;
        beat_d  = '0;
        state_d = IDLE;
      end else begin
        shreg_d = shreg_q >> OUT_W;
        beat_d  = beat_q + 1'b1;
      end
    end
  end

  // State, shift register and beat counter; reset drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_type_param_serializer.sv
// Bench for type_param_serializer. Three instances cover the default
// configuration, a padded 13-bit payload and a single-beat configuration.
// A word-level reference model predicts every output each cycle.
module tb_type_param_serializer;
  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  type_param_serializer_if #(.T(logic [11:0]), .OUT_W(4))  bus0 ();
  type_param_serializer_if #(.T(logic [12:0]), .OUT_W(4))  bus1 ();
  type_param_serializer_if #(.T(logic [11:0]), .OUT_W(16)) bus2 ();

  type_param_serializer #(.T(logic [11:0]), .OUT_W(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  type_param_serializer #(.T(logic [12:0]), .OUT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  type_param_serializer #(.T(logic [11:0]), .OUT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        drv_valid [NCH];
  logic        drv_ready [NCH];
  logic [15:0] drv_data  [NCH];

  logic        obs_valid [NCH];
  logic        obs_last  [NCH];
  logic        obs_ready [NCH];
  logic [15:0] obs_data  [NCH];
  logic [3:0]  obs_beat  [NCH];

  assign bus0.in_valid  = drv_valid[0];
  assign bus0.in_data   = drv_data[0][11:0];
  assign bus0.out_ready = drv_ready[0];
  assign bus1.in_valid  = drv_valid[1];
  assign bus1.in_data   = drv_data[1][12:0];
  assign bus1.out_ready = drv_ready[1];
  assign bus2.in_valid  = drv_valid[2];
  assign bus2.in_data   = drv_data[2][11:0];
  assign bus2.out_ready = drv_ready[2];

  assign obs_valid[0] = bus0.out_valid;
  assign obs_last[0]  = bus0.out_last;
  assign obs_ready[0] = bus0.in_ready;
  assign obs_data[0]  = 16'(bus0.out_data);
  assign obs_beat[0]  = {2'b00, bus0.out_beat};
  assign obs_valid[1] = bus1.out_valid;
  assign obs_last[1]  = bus1.out_last;
  assign obs_ready[1] = bus1.in_ready;
  assign obs_data[1]  = 16'(bus1.out_data);
  assign obs_beat[1]  = {2'b00, bus1.out_beat};
  assign obs_valid[2] = bus2.out_valid;
  assign obs_last[2]  = bus2.out_last;
  assign obs_ready[2] = bus2.in_ready;
  assign obs_data[2]  = bus2.out_data;
  assign obs_beat[2]  = {3'b000, bus2.out_beat};

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the word currently being sent and which beat is showing.
  logic        busy     [NCH];
  logic [15:0] word     [NCH];
  int          beat_idx [NCH];
  logic        nxt_busy [NCH];
  logic [15:0] nxt_word [NCH];
  int          nxt_beat [NCH];

  function automatic int width_of(input int ch);
    return (ch == 1) ? 13 : 12;
  endfunction

  function automatic int beatw_of(input int ch);
    return (ch == 2) ? 16 : 4;
  endfunction

  function automatic int nbeats_of(input int ch);
    return (width_of(ch) + beatw_of(ch) - 1) / beatw_of(ch);
  endfunction

  function automatic logic [15:0] beat_value(input int ch, input logic [15:0] w, input int i);
    int v;
    v = int'(w) >> (i * beatw_of(ch));
    return 16'(v & ((1 << beatw_of(ch)) - 1));
  endfunction

  task automatic compare(input string tag, input int ch, input logic [15:0] observed,
                         input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s ch%0d: observed %0h, expected %0h", tag, ch, observed, expected);
    end
  endtask

  task automatic check_output(input string tag);
    for (int ch = 0; ch < NCH; ch++) begin
      logic exp_last;
      logic exp_ready;
      exp_last  = busy[ch] && (beat_idx[ch] == nbeats_of(ch) - 1);
      exp_ready = !busy[ch] || (exp_last && drv_ready[ch]);
      compare({tag, "/valid"}, ch, 16'(obs_valid[ch]), 16'(busy[ch]));
      compare({tag, "/last"},  ch, 16'(obs_last[ch]),  16'(exp_last));
      compare({tag, "/ready"}, ch, 16'(obs_ready[ch]), 16'(exp_ready));
      if (busy[ch]) begin
        compare({tag, "/data"}, ch, obs_data[ch], beat_value(ch, word[ch], beat_idx[ch]));
        compare({tag, "/beat"}, ch, 16'(obs_beat[ch]), 16'(beat_idx[ch]));
      end
      nxt_busy[ch] = busy[ch];
      nxt_word[ch] = word[ch];
      nxt_beat[ch] = beat_idx[ch];
      if (!rst_n) begin
        nxt_busy[ch] = 1'b0;
      end else if (drv_valid[ch] && exp_ready) begin
        nxt_busy[ch] = 1'b1;
        nxt_word[ch] = 16'(32'(drv_data[ch]) & ((1 << width_of(ch)) - 1));
        nxt_beat[ch] = 0;
      end else if (busy[ch] && drv_ready[ch]) begin
        if (exp_last) nxt_busy[ch] = 1'b0;
        else          nxt_beat[ch] = beat_idx[ch] + 1;
      end
    end
  endtask

  // One clock cycle: check current outputs, then advance the model at the edge.
  task automatic tick(input string tag);
    #2;
    check_output(tag);
    @(posedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      busy[ch]     = nxt_busy[ch];
      word[ch]     = nxt_word[ch];
      beat_idx[ch] = nxt_beat[ch];
    end
    #1;
  endtask

  task automatic expect_beat(input string tag, input int ch, input logic [15:0] d,
                             input int b, input logic l);
    compare({tag, "/valid"}, ch, 16'(obs_valid[ch]), 16'd1);
    compare({tag, "/data"},  ch, obs_data[ch], d);
    compare({tag, "/beat"},  ch, 16'(obs_beat[ch]), 16'(b));
    compare({tag, "/last"},  ch, 16'(obs_last[ch]), 16'(l));
  endtask

  task automatic expect_reset(input string tag);
    for (int ch = 0; ch < NCH; ch++) begin
      compare({tag, "/valid"}, ch, 16'(obs_valid[ch]), 16'd0);
      compare({tag, "/data"},  ch, obs_data[ch], 16'd0);
      compare({tag, "/beat"},  ch, 16'(obs_beat[ch]), 16'd0);
      compare({tag, "/last"},  ch, 16'(obs_last[ch]), 16'd0);
      compare({tag, "/ready"}, ch, 16'(obs_ready[ch]), 16'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      drv_valid[ch] = 1'b0;
      drv_ready[ch] = 1'b1;
      drv_data[ch]  = 16'h0000;
      busy[ch]      = 1'b0;
      word[ch]      = 16'h0000;
      beat_idx[ch]  = 0;
    end

    // Reset state.
    #2;
    expect_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic serialization of 12'hABC.
    drv_valid[0] = 1'b1; drv_data[0] = 16'h0ABC;
    tick("basic");
    expect_beat("basic0", 0, 16'hC, 0, 1'b0);
    drv_valid[0] = 1'b0;
    tick("basic");
    expect_beat("basic1", 0, 16'hB, 1, 1'b0);
    tick("basic");
    expect_beat("basic2", 0, 16'hA, 2, 1'b1);
    tick("basic");
    compare("basic_done/valid", 0, 16'(obs_valid[0]), 16'd0);

    // Backpressure on beat 1 of 12'h5A3.
    drv_valid[0] = 1'b1; drv_data[0] = 16'h05A3;
    tick("bp");
    expect_beat("bp0", 0, 16'h3, 0, 1'b0);
    drv_valid[0] = 1'b0;
    tick("bp");
    drv_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("bp_stall");
      expect_beat("bp_stall", 0, 16'hA, 1, 1'b0);
    end
    drv_ready[0] = 1'b1;
    tick("bp");
    expect_beat("bp2", 0, 16'h5, 2, 1'b1);
    tick("bp");

    // Back-to-back words 12'h123 then 12'h456.
    drv_valid[0] = 1'b1; drv_data[0] = 16'h0123;
    tick("b2b");
    expect_beat("b2b0", 0, 16'h3, 0, 1'b0);
    drv_data[0] = 16'h0456;
    tick("b2b");
    expect_beat("b2b1", 0, 16'h2, 1, 1'b0);
    tick("b2b");
    expect_beat("b2b2", 0, 16'h1, 2, 1'b1);
    compare("b2b_overlap/ready", 0, 16'(obs_ready[0]), 16'd1);
    tick("b2b");
    expect_beat("b2b3", 0, 16'h6, 0, 1'b0);
    drv_valid[0] = 1'b0;
    tick("b2b");
    expect_beat("b2b4", 0, 16'h5, 1, 1'b0);
    tick("b2b");
    expect_beat("b2b5", 0, 16'h4, 2, 1'b1);
    tick("b2b");

    // Padding: 13-bit payload 13'h1ABC over 4-bit beats.
    drv_valid[1] = 1'b1; drv_data[1] = 16'h1ABC;
    tick("pad");
    drv_valid[1] = 1'b0;
    expect_beat("pad0", 1, 16'hC, 0, 1'b0);
    tick("pad");
    expect_beat("pad1", 1, 16'hB, 1, 1'b0);
    tick("pad");
    expect_beat("pad2", 1, 16'hA, 2, 1'b0);
    tick("pad");
    expect_beat("pad3", 1, 16'h1, 3, 1'b1);
    tick("pad");

    // Single beat: 12'hFED over a 16-bit beat, upper garbage must not leak.
    drv_valid[2] = 1'b1; drv_data[2] = 16'hFFED;
    tick("single");
    drv_valid[2] = 1'b0;
    expect_beat("single0", 2, 16'h0FED, 0, 1'b1);
    tick("single");

    // Asynchronous reset during beat 1, then a fresh word.
    drv_valid[0] = 1'b1; drv_data[0] = 16'h0321;
    tick("rst");
    drv_valid[0] = 1'b0;
    tick("rst");
    expect_beat("rst_beat1", 0, 16'h2, 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset("rst_mid");
    for (int ch = 0; ch < NCH; ch++) busy[ch] = 1'b0;
    @(posedge clk);
    #1;
    tick("rst_hold");
    rst_n = 1'b1;
    drv_valid[0] = 1'b1; drv_data[0] = 16'h0789;
    tick("post_rst");
    drv_valid[0] = 1'b0;
    expect_beat("post_rst0", 0, 16'h9, 0, 1'b0);
    tick("post_rst");
    expect_beat("post_rst1", 0, 16'h8, 1, 1'b0);
    tick("post_rst");
    expect_beat("post_rst2", 0, 16'h7, 2, 1'b1);
    tick("post_rst");

    // Randomized traffic on all three instances against the model.
    for (int n = 0; n < 400; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        drv_valid[ch] = 1'($urandom_range(0, 1));
        drv_ready[ch] = ($urandom_range(0, 9) < 7);
        drv_data[ch]  = 16'($urandom);
      end
      tick("rand");
    end

    // Drain.
    for (int ch = 0; ch < NCH; ch++) begin
      drv_valid[ch] = 1'b0;
      drv_ready[ch] = 1'b1;
    end
    repeat (6) tick("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
